// File: rtl/mainfsm_pkg.sv
// ============================================================================
// Module  : mainfsm_pkg
// Purpose : Shared encodings for the multicycle main control FSM. Holds the
//           4-bit state codes, the supported opcodes, the ALUOp codes sent to
//           aludec and the datapath mux-select codes.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_IALU) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mainfsm.sv
// ============================================================================
// Module  : mainfsm
// Purpose : Multicycle main control FSM. Steps each instruction through
//           fetch/decode/execute/memory/writeback, one state per clock, and
//           drives every datapath enable, mux select and ALUOp for aludec.
//           Memory wait states are handshaked with MemReq/MemReady.
// Ports   : clk, reset (async, active-high), op[6:0], MemReady
//           -> MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
//              ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp[1:0],
//              IllegalInstr, state_dbg[3:0]
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       IllegalInstr,
  output logic [3:0] state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;

  generate
    if (USE_MEM_READY != 0) begin : g_mem_ready
      assign w_mem_ready = MemReady;
    end else begin : g_mem_fixed
      assign w_mem_ready = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_IALU:      w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;   // MEMWB, ALUWB, BEQ and unused codes
    endcase
  end

  // The state register already resets to FETCH, but FETCH asserts MemReq;
  // gating on reset keeps every output quiet while reset is held.
  always_comb begin
    MemReq       = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCUpdate     = 1'b0;
    Branch       = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    ALUOp        = ALUOP_ADD;
    IllegalInstr = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = w_mem_ready;
          PCUpdate  = w_mem_ready;
        end
        S_DECODE: begin
          // Precompute the branch target while the opcode is decoded.
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALUOP_ADD;
          IllegalInstr = !op_supported(op);
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTER: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_EXECUTEI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
        end
        S_JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCUpdate = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_SUB;
          Branch  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mainfsm.sv
// ============================================================================
// Module  : tb_mainfsm
// Purpose : Directed self-checking bench for mainfsm. Each task starts on a
//           falling edge with the FSM in FETCH, drives per-cycle inputs,
//           checks outputs 1 ns later, and ends back in FETCH.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mainfsm;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2,
                         MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
                         EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8,
                         JALS = 4'd9, BEQS = 4'd10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic       MemReady = 1'b0;
  logic       MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       IllegalInstr;
  logic [3:0] state_dbg;

  int total  = 0;
  int passed = 0;

  mainfsm #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .MemReq(MemReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
    .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .IllegalInstr(IllegalInstr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 reset = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (state_dbg !== FETCH) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, FETCH);
    else passed++;
    total++;
    if ({MemReq, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, IllegalInstr} !== 7'b0)
      $display("FAIL reset_enables got=%b exp=0000000",
               {MemReq, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, IllegalInstr});
    else passed++;
    total++;
    if ({ALUSrcA, ALUSrcB, ResultSrc, ALUOp} !== 8'b0)
      $display("FAIL reset_selects got=%b exp=00000000", {ALUSrcA, ALUSrcB, ResultSrc, ALUOp});
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if ({MemReq, IRWrite, PCUpdate, ALUSrcB, ResultSrc} !== 7'b1111010)
      $display("FAIL release_fetch got=%b exp=1111010", {MemReq, IRWrite, PCUpdate, ALUSrcB, ResultSrc});
    else passed++;
  endtask

  task automatic test_lw();
    logic [3:0] es[5] = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
    logic       rw[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       rq[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0000011;
    MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (state_dbg !== es[i] || RegWrite !== rw[i] || MemReq !== rq[i])
        $display("FAIL lw_cycle%0d got st=%0d rw=%b rq=%b exp st=%0d rw=%b rq=%b",
                 i + 1, state_dbg, RegWrite, MemReq, es[i], rw[i], rq[i]);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (state_dbg !== FETCH) $display("FAIL lw_return got=%0d exp=%0d", state_dbg, FETCH);
    else passed++;
  endtask

  task automatic test_sw_wait();
    logic [3:0] es[7] = '{FETCH, DECODE, MEMADR, MEMWRITE, MEMWRITE, MEMWRITE, MEMWRITE};
    logic       mr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       mw[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    op = 7'b0100011;
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      #1;
      total++;
      if (state_dbg !== es[i] || MemWrite !== mw[i] || (i >= 3 && (MemReq !== 1'b1 || AdrSrc !== 1'b1)))
        $display("FAIL sw_cycle%0d got st=%0d mw=%b rq=%b adr=%b exp st=%0d mw=%b",
                 i + 1, state_dbg, MemWrite, MemReq, AdrSrc, es[i], mw[i]);
      else passed++;
      @(negedge clk);
    end
    MemReady = 1'b1;
    #1;
    total++;
    if (state_dbg !== FETCH || MemWrite !== 1'b0)
      $display("FAIL sw_return got st=%0d mw=%b exp st=%0d mw=0", state_dbg, MemWrite, FETCH);
    else passed++;
  endtask

  task automatic test_beq();
    logic [3:0] es[3] = '{FETCH, DECODE, BEQS};
    logic [1:0] ao[3] = '{2'b00, 2'b00, 2'b01};
    logic       br[3] = '{1'b0, 1'b0, 1'b1};
    op = 7'b1100011;
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (state_dbg !== es[i] || ALUOp !== ao[i] || Branch !== br[i] || (i == 2 && ALUSrcA !== 2'b10))
        $display("FAIL beq_cycle%0d got st=%0d aluop=%b br=%b srca=%b exp st=%0d aluop=%b br=%b",
                 i + 1, state_dbg, ALUOp, Branch, ALUSrcA, es[i], ao[i], br[i]);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (state_dbg !== FETCH || Branch !== 1'b0)
      $display("FAIL beq_return got st=%0d br=%b exp st=%0d br=0", state_dbg, Branch, FETCH);
    else passed++;
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    MemReady = 1'b1;
    #1;
    total++;
    if (state_dbg !== FETCH || IllegalInstr !== 1'b0)
      $display("FAIL illegal_fetch got st=%0d ill=%b exp st=%0d ill=0", state_dbg, IllegalInstr, FETCH);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state_dbg !== DECODE || IllegalInstr !== 1'b1)
      $display("FAIL illegal_decode got st=%0d ill=%b exp st=%0d ill=1", state_dbg, IllegalInstr, DECODE);
    else passed++;
    total++;
    if ({IRWrite, PCUpdate, RegWrite, MemWrite, Branch, MemReq} !== 6'b0)
      $display("FAIL illegal_enables got=%b exp=000000",
               {IRWrite, PCUpdate, RegWrite, MemWrite, Branch, MemReq});
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state_dbg !== FETCH || IllegalInstr !== 1'b0)
      $display("FAIL illegal_return got st=%0d ill=%b exp st=%0d ill=0", state_dbg, IllegalInstr, FETCH);
    else passed++;
  endtask

  // R-type with two FETCH wait cycles, then I-ALU with a zero-wait fetch.
  task automatic test_alu();
    logic [3:0] es[6] = '{FETCH, FETCH, FETCH, DECODE, EXECR, ALUWB};
    logic       mr[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       ir[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ei[4] = '{FETCH, DECODE, EXECI, ALUWB};
    op = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      MemReady = mr[i];
      #1;
      total++;
      if (state_dbg !== es[i] || IRWrite !== ir[i] || PCUpdate !== ir[i])
        $display("FAIL rtype_cycle%0d got st=%0d ir=%b pcu=%b exp st=%0d ir=%b",
                 i + 1, state_dbg, IRWrite, PCUpdate, es[i], ir[i]);
      else passed++;
      if (i == 4) begin
        total++;
        if (ALUOp !== 2'b10 || ALUSrcB !== 2'b00 || ALUSrcA !== 2'b10)
          $display("FAIL rtype_exec got aluop=%b srcb=%b srca=%b exp aluop=10 srcb=00 srca=10",
                   ALUOp, ALUSrcB, ALUSrcA);
        else passed++;
      end
      if (i == 5) begin
        total++;
        if (RegWrite !== 1'b1) $display("FAIL rtype_wb got rw=%b exp rw=1", RegWrite);
        else passed++;
      end
      @(negedge clk);
    end
    op = 7'b0010011;
    MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state_dbg !== ei[i] || RegWrite !== (i == 3) ||
          (i == 2 && (ALUOp !== 2'b10 || ALUSrcB !== 2'b01)))
        $display("FAIL itype_cycle%0d got st=%0d rw=%b aluop=%b srcb=%b exp st=%0d",
                 i + 1, state_dbg, RegWrite, ALUOp, ALUSrcB, ei[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [3:0] es[4] = '{FETCH, DECODE, JALS, ALUWB};
    op = 7'b1101111;
    MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state_dbg !== es[i] || (i == 2 && {PCUpdate, ALUSrcA, ALUSrcB} !== 5'b10110) ||
          (i == 3 && (RegWrite !== 1'b1 || PCUpdate !== 1'b0)))
        $display("FAIL jal_cycle%0d got st=%0d pcu=%b srca=%b srcb=%b rw=%b exp st=%0d",
                 i + 1, state_dbg, PCUpdate, ALUSrcA, ALUSrcB, RegWrite, es[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011;
    MemReady = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (state_dbg !== MEMWB || RegWrite !== 1'b1)
      $display("FAIL midrst_pre got st=%0d rw=%b exp st=%0d rw=1", state_dbg, RegWrite, MEMWB);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (state_dbg !== FETCH || RegWrite !== 1'b0 || MemWrite !== 1'b0)
      $display("FAIL midrst_async got st=%0d rw=%b mw=%b exp st=%0d rw=0 mw=0",
               state_dbg, RegWrite, MemWrite, FETCH);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state_dbg !== FETCH || MemReq !== 1'b0 || RegWrite !== 1'b0)
      $display("FAIL midrst_hold got st=%0d rq=%b rw=%b exp st=%0d rq=0 rw=0",
               state_dbg, MemReq, RegWrite, FETCH);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (MemReq !== 1'b1 || IRWrite !== 1'b1)
      $display("FAIL midrst_release got rq=%b ir=%b exp rq=1 ir=1", MemReq, IRWrite);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state_dbg !== DECODE) $display("FAIL midrst_resume got st=%0d exp st=%0d", state_dbg, DECODE);
    else passed++;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (state_dbg !== FETCH) $display("FAIL midrst_finish got st=%0d exp st=%0d", state_dbg, FETCH);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_alu();
    test_jal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
